fft_s2p_buffer: RTL



---
 rtl/fft_pkg.sv | 35 +++
 rtl/fft_s2p_ctrl.sv | 109 ++++++++++
 rtl/fft_s2p_buffer.sv | 83 ++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared widths, state encoding and group pack/unpack for the 16-point FFT front end
package fft_pkg;

    localparam int CW  = 17;
    localparam int FW  = 2 * CW;
    localparam int GW  = 4 * FW;
    localparam int NPT = 16;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        ISSUE1  = 2'd1,
        WAIT_WB = 2'd2,
        ISSUE2  = 2'd3
    } state_t;

    typedef logic [FW-1:0] field_t;

    // Group layout is {in4, in3, in2, in1}, in1 in the least significant field.
    function automatic logic [GW-1:0] pack_group(input field_t f1, input field_t f2,
                                                  input field_t f3, input field_t f4);
        return {f4, f3, f2, f1};
    endfunction

    function automatic field_t unpack_field(input logic [GW-1:0] g, input logic [1:0] idx);
        field_t f;
        case (idx)
            2'd0:    f = g[FW-1:0];
            2'd1:    f = g[2*FW-1:FW];
            2'd2:    f = g[3*FW-1:2*FW];
            default: f = g[4*FW-1:3*FW];
        endcase
        return f;
    endfunction

endpackage

// File: rtl/fft_s2p_ctrl.sv
// rtl/fft_s2p_ctrl.sv - frame FSM with load pointer, issue counter and writeback counter
module fft_s2p_ctrl
    import fft_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_in_valid,
    input  logic       i_wb_valid,
    input  logic [2:0] i_wb_rotation,
    output state_t     o_state,
    output logic [3:0] o_wp,
    output logic [1:0] o_cnt,
    output logic       o_load_we,
    output logic       o_wb_we,
    output logic       o_frame_done
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_wp;
    logic [3:0] w_wp_nxt;
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_nxt;
    logic [2:0] r_wb_cnt;
    logic [2:0] w_wb_cnt_nxt;
    logic [2:0] w_wb_sum;
    logic       w_wb_all;
    logic       r_frame_done;
    logic       w_frame_done_nxt;
    logic       w_load_we;
    logic       w_wb_we;

    assign w_load_we = (r_state == LOAD) && i_in_valid && i_rst_n;
    assign w_wb_we   = ((r_state == ISSUE1) || (r_state == WAIT_WB)) && i_wb_valid
                       && !i_wb_rotation[2];
    // Counting the writeback accepted this cycle lets stage 2 start right after the 4th write.
    assign w_wb_sum  = r_wb_cnt + {2'b00, w_wb_we};
    assign w_wb_all  = w_wb_sum[2];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= LOAD;
            r_wp         <= '0;
            r_cnt        <= '0;
            r_wb_cnt     <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wp         <= w_wp_nxt;
            r_cnt        <= w_cnt_nxt;
            r_wb_cnt     <= w_wb_cnt_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_wp_nxt         = r_wp;
        w_cnt_nxt        = r_cnt;
        w_wb_cnt_nxt     = w_wb_sum;
        w_frame_done_nxt = 1'b0;
        case (r_state)
            LOAD: begin
                if (w_load_we) begin
                    w_wp_nxt = r_wp + 4'd1;
                    if (r_wp == 4'(NPT - 1)) begin
                        w_state_nxt  = ISSUE1;
                        w_cnt_nxt    = '0;
                        w_wb_cnt_nxt = '0;
                    end
                end
            end
            ISSUE1: begin
                w_cnt_nxt = r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    if (w_wb_all) begin
                        w_state_nxt  = ISSUE2;
                        w_wb_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = WAIT_WB;
                    end
                end
            end
            WAIT_WB: begin
                if (w_wb_all) begin
                    w_state_nxt  = ISSUE2;
                    w_cnt_nxt    = '0;
                    w_wb_cnt_nxt = '0;
                end
            end
            ISSUE2: begin
                w_cnt_nxt = r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    w_state_nxt      = LOAD;
                    w_frame_done_nxt = 1'b1;
                end
            end
            default: w_state_nxt = LOAD;
        endcase
    end

    assign o_state      = r_state;
    assign o_wp         = r_wp;
    assign o_cnt        = r_cnt;
    assign o_load_we    = w_load_we;
    assign o_wb_we      = w_wb_we;
    assign o_frame_done = r_frame_done;

endmodule

// File: rtl/fft_s2p_buffer.sv
// rtl/fft_s2p_buffer.sv - serial-to-parallel frame buffer feeding the radix-4 butterfly
module fft_s2p_buffer
    import fft_pkg::*;
#(
    parameter int IN_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [IN_W-1:0] in_re,
    input  logic [IN_W-1:0] in_im,
    output logic            in_ready,
    output logic [GW-1:0]   calc_in,
    output logic            calc_valid,
    output logic [2:0]      rotation,
    input  logic            wb_valid,
    input  logic [2:0]      wb_rotation,
    input  logic [GW-1:0]   wb_data,
    output logic            busy,
    output logic            frame_done
);

    state_t        w_state;
    logic [3:0]    w_wp;
    logic [1:0]    w_cnt;
    logic          w_load_we;
    logic          w_wb_we;
    logic          w_frame_done;
    logic [CW-1:0] w_re_ext;
    logic [CW-1:0] w_im_ext;
    field_t        w_f [4];
    logic [GW-1:0] w_group;
    field_t        r_mem [NPT];

    fft_s2p_ctrl u_ctrl (
        .i_clk         (clk),
        .i_rst_n       (reset),
        .i_in_valid    (in_valid),
        .i_wb_valid    (wb_valid),
        .i_wb_rotation (wb_rotation),
        .o_state       (w_state),
        .o_wp          (w_wp),
        .o_cnt         (w_cnt),
        .o_load_we     (w_load_we),
        .o_wb_we       (w_wb_we),
        .o_frame_done  (w_frame_done)
    );

    assign w_re_ext = {{(CW - IN_W){in_re[IN_W-1]}}, in_re};
    assign w_im_ext = {{(CW - IN_W){in_im[IN_W-1]}}, in_im};

    // Sample storage is deliberately left uninitialised by reset; a new frame overwrites it.
    always_ff @(posedge clk) begin
        if (w_load_we) begin
            r_mem[w_wp] <= {w_re_ext, w_im_ext};
        end
        if (w_wb_we) begin
            for (int j = 0; j < 4; j++) begin
                r_mem[{2'(j), wb_rotation[1:0]}] <= unpack_field(wb_data, 2'(j));
            end
        end
    end

    // Stage 1 reads column k (stride 4), stage 2 reads row m (contiguous).
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            if (w_state == ISSUE1) begin
                w_f[j] = r_mem[{2'(j), w_cnt}];
            end else begin
                w_f[j] = r_mem[{w_cnt, 2'(j)}];
            end
        end
    end

    assign w_group    = pack_group(w_f[0], w_f[1], w_f[2], w_f[3]);
    assign calc_valid = (w_state == ISSUE1) || (w_state == ISSUE2);
    assign calc_in    = calc_valid ? w_group : '0;
    assign rotation   = calc_valid ? {w_state == ISSUE2, w_cnt} : 3'd0;
    assign in_ready   = (w_state == LOAD);
    assign busy       = (w_state != LOAD);
    assign frame_done = w_frame_done;

endmodule
